// File: rtl/cbr_ts_scheduler.sv
// Constant-bitrate TS read scheduler: a phase accumulator paces byte slots; each packet slot carries a FIFO video packet or a null packet.
// Latency: fifo_rd_en in the tick cycle t; ts_* registered at t+2; packet counters update at t+1 of the eop tick.
// Backpressure: none downstream; FIFO reads are issued only for packets whose full length was counted at packet start.
module cbr_ts_scheduler #(
  parameter int PKT_LEN = 188,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] rate_inc,
  input  logic [CNT_W-1:0] fifo_rd_count,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic [7:0]       ts_data,
  output logic             ts_valid,
  output logic             ts_sop,
  output logic             ts_eop,
  output logic             ts_null,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      null_cnt
);

  localparam int IDX_W = $clog2(PKT_LEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VID  = 2'd1;
  localparam logic [1:0] ST_NUL  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic             issue;
  logic             pkt_start;
  logic             pkt_last;
  logic             pkt_vid;
  logic [7:0]       null_byte;

  // First pipeline stage: byte slot attributes one cycle after the tick.
  logic             s1_valid;
  logic             s1_sop;
  logic             s1_eop;
  logic             s1_null;
  logic [7:0]       s1_byte;

  // Slot pacing, packet type selection and null template lookup.
  always_comb begin
    acc_sum   = {1'b0, acc} + {1'b0, rate_inc};
    tick      = acc_sum[ACC_W];
    // Idle only starts a packet when enabled; a packet in flight always runs to its end.
    issue     = tick && ((state != ST_IDLE) || enable);
    pkt_start = (idx == '0);
    pkt_last  = (idx == IDX_W'(PKT_LEN - 1));
    // Type is fixed at byte 0 from the fill level; later bytes follow the latched state.
    pkt_vid   = pkt_start ? (fifo_rd_count >= CNT_W'(PKT_LEN)) : (state == ST_VID);
    fifo_rd_en = issue && pkt_vid;
    case (idx)
      IDX_W'(0): null_byte = 8'h47;
      IDX_W'(1): null_byte = 8'h1F;
      IDX_W'(2): null_byte = 8'hFF;
      IDX_W'(3): null_byte = 8'h10;
      default:   null_byte = 8'hFF;
    endcase
  end

  // Phase accumulator; parked at zero while idle and disabled so restarts are deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if ((state == ST_IDLE) && !enable) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[ACC_W-1:0];
    end
  end

  // Packet sequencing: byte index, packet type state and sent-packet counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pkt_cnt  <= '0;
      null_cnt <= '0;
    end else if (issue) begin
      if (pkt_last) begin
        idx   <= '0;
        state <= enable ? (pkt_vid ? ST_VID : ST_NUL) : ST_IDLE;
        if (pkt_vid) begin
          pkt_cnt <= pkt_cnt + 16'd1;
        end else begin
          null_cnt <= null_cnt + 16'd1;
        end
      end else begin
        idx   <= idx + IDX_W'(1);
        state <= pkt_vid ? ST_VID : ST_NUL;
      end
    end
  end

  // Stage 1: capture slot framing while the FIFO read data is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_null  <= 1'b0;
      s1_byte  <= 8'h00;
    end else begin
      s1_valid <= issue;
      s1_sop   <= issue && pkt_start;
      s1_eop   <= issue && pkt_last;
      s1_null  <= issue && !pkt_vid;
      s1_byte  <= null_byte;
    end
  end

  // Stage 2: output register; data and null flag hold between byte slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_valid <= 1'b0;
      ts_sop   <= 1'b0;
      ts_eop   <= 1'b0;
      ts_null  <= 1'b0;
      ts_data  <= 8'h00;
    end else begin
      ts_valid <= s1_valid;
      ts_sop   <= s1_sop;
      ts_eop   <= s1_eop;
      if (s1_valid) begin
        ts_null <= s1_null;
        ts_data <= s1_null ? s1_byte : fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_cbr_ts_scheduler.sv
// Bench for cbr_ts_scheduler: directed scenarios plus random rate/fill phases.
// Expected byte timing comes from the closed form tick_k = ceil(k * 2^24 / rate).
// Packet content comes from a FIFO memory image and the null packet definition.
module tb_cbr_ts_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] rate_inc;
  logic [12:0] fifo_rd_count;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en;
  logic [7:0]  ts_data;
  logic        ts_valid;
  logic        ts_sop;
  logic        ts_eop;
  logic        ts_null;
  logic [15:0] pkt_cnt;
  logic [15:0] null_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_pkt  = 16'd0;
  logic [15:0] exp_null = 16'd0;

  // FIFO model: read data appears one cycle after the read request.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_ptr = 16'd0;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         sop;
    bit         eop;
    bit         nul;
  } ev_t;

  cbr_ts_scheduler #(.PKT_LEN(188), .ACC_W(24), .CNT_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_inc(rate_inc),
    .fifo_rd_count(fifo_rd_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_sop(ts_sop), .ts_eop(ts_eop),
    .ts_null(ts_null), .pkt_cnt(pkt_cnt), .null_cnt(null_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 16'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] null_ref(input int i);
    if (i == 0) return 8'h47;
    if (i == 1) return 8'h1F;
    if (i == 3) return 8'h10;
    return 8'hFF;
  endfunction

  // Enabled cycle (1-based) on which the k-th byte slot of a run is issued.
  function automatic longint tick_j(input longint k, input longint r);
    return ((k << 24) + r - 1) / r;
  endfunction

  // Starts from idle; enable rises at rel 0, count switches to cnt_b at rel s_rel, enable falls at rel d_rel.
  task automatic run_phase(input string tag, input logic [23:0] rate, input logic [12:0] cnt_a,
                           input logic [12:0] cnt_b, input int s_rel, input int d_rel,
                           output int n_rd, output int n_v, output int first_rd,
                           output int first_sop, output int last_eop);
    ev_t evq[$];
    int rdq[$];
    ev_t e;
    logic [15:0] base;
    int nv, p, last;
    bit cont, vid, exp_rd, exp_v;
    longint js, j;
    base = rd_ptr;
    nv = 0; p = 0; cont = 1'b1; j = 0;
    while (cont && p < 32) begin
      js  = tick_j(longint'(188 * p + 1), longint'(rate));
      vid = ((((js - 1) >= s_rel) ? cnt_b : cnt_a) >= 13'd188);
      for (int i = 0; i < 188; i++) begin
        j     = tick_j(longint'(188 * p + 1 + i), longint'(rate));
        e.cyc = int'(j) + 1;
        e.b   = vid ? mem[base + 16'(nv)] : null_ref(i);
        e.sop = (i == 0);
        e.eop = (i == 187);
        e.nul = !vid;
        evq.push_back(e);
        if (vid) begin
          rdq.push_back(int'(j) - 1);
          nv++;
        end
      end
      cont = ((j - 1) < d_rel);
      p++;
    end
    last = evq[$].cyc;
    n_rd = 0; n_v = 0; first_rd = -1; first_sop = -1; last_eop = -1;
    @(negedge clk);
    rate_inc      = rate;
    fifo_rd_count = (s_rel <= 0) ? cnt_b : cnt_a;
    enable        = 1'b1;
    for (int rel = 1; rel <= last + 4; rel++) begin
      @(negedge clk);
      if (rel == s_rel) fifo_rd_count = cnt_b;
      if (rel == d_rel) enable = 1'b0;
      #1;
      exp_rd = (rdq.size() > 0) && (rdq[0] == rel);
      if (exp_rd) void'(rdq.pop_front());
      chk({tag, " rd_en"}, 32'(fifo_rd_en), 32'(exp_rd));
      if (fifo_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = rel;
      end
      exp_v = (evq.size() > 0) && (evq[0].cyc == rel);
      chk({tag, " valid"}, 32'(ts_valid), 32'(exp_v));
      if (ts_valid) begin
        n_v++;
        if (ts_sop && first_sop < 0) first_sop = rel;
        if (ts_eop) last_eop = rel;
      end
      if (exp_v) begin
        e = evq.pop_front();
        if (e.eop) begin
          if (e.nul) exp_null = exp_null + 16'd1;
          else       exp_pkt  = exp_pkt + 16'd1;
        end
        if (ts_valid) begin
          chk({tag, " data"}, 32'(ts_data), 32'(e.b));
          chk({tag, " sop"},  32'(ts_sop),  32'(e.sop));
          chk({tag, " eop"},  32'(ts_eop),  32'(e.eop));
          chk({tag, " null"}, 32'(ts_null), 32'(e.nul));
          if (e.eop) begin
            chk({tag, " pkt_cnt"},  32'(pkt_cnt),  32'(exp_pkt));
            chk({tag, " null_cnt"}, 32'(null_cnt), 32'(exp_null));
          end
        end
      end
    end
    chk({tag, " idle acc"}, 32'(dut.acc), 32'd0);
    chk({tag, " idle idx"}, 32'(dut.idx), 32'd0);
  endtask

  initial begin
    int n_rd, n_v, f_rd, f_sop, l_eop, seen;
    logic [15:0] base;
    logic [23:0] r_rate;
    int d;
    rst_n = 1'b0; enable = 1'b0; rate_inc = 24'd0; fifo_rd_count = 13'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst ts_data",    32'(ts_data),    32'd0);
    chk("rst ts_valid",   32'(ts_valid),   32'd0);
    chk("rst ts_sop",     32'(ts_sop),     32'd0);
    chk("rst ts_eop",     32'(ts_eop),     32'd0);
    chk("rst ts_null",    32'(ts_null),    32'd0);
    chk("rst pkt_cnt",    32'(pkt_cnt),    32'd0);
    chk("rst null_cnt",   32'(null_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero rate never ticks.
    enable = 1'b1; rate_inc = 24'd0; fifo_rd_count = 13'd200; seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (fifo_rd_en || ts_valid) seen++;
    end
    chk("rate0 activity", 32'(seen), 32'd0);
    chk("rate0 acc", 32'(dut.acc), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Video packet 0..187 at half rate, enable dropped at idx 50.
    base = rd_ptr;
    for (int i = 0; i < 188; i++) mem[base + 16'(i)] = 8'(i);
    run_phase("vid", 24'h800000, 13'd200, 13'd200, 0, int'(tick_j(51, 24'h800000)) - 1,
              n_rd, n_v, f_rd, f_sop, l_eop);
    chk("vid rd pulses", 32'(n_rd), 32'd188);
    chk("vid bytes", 32'(n_v), 32'd188);
    chk("vid first tick", 32'(f_rd), 32'd1);
    chk("vid sop latency", 32'(f_sop - f_rd), 32'd2);
    chk("vid pkt_cnt", 32'(pkt_cnt), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (ts_valid || dut.acc != 24'd0) seen++;
    end
    chk("vid quiet after drop", 32'(seen), 32'd0);

    // Null packet; count rises mid-packet, so the next packet is video.
    run_phase("nul", 24'h800000, 13'd100, 13'd188, int'(tick_j(100, 24'h800000)) - 1,
              int'(tick_j(200, 24'h800000)), n_rd, n_v, f_rd, f_sop, l_eop);
    chk("nul rd pulses", 32'(n_rd), 32'd188);
    chk("nul null_cnt", 32'(null_cnt), 32'd1);
    chk("nul pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Max rate: continuous output over four packets.
    run_phase("max", 24'hFFFFFF, 13'd4000, 13'd4000, 0, int'(tick_j(600, 24'hFFFFFF)),
              n_rd, n_v, f_rd, f_sop, l_eop);
    chk("max first tick", 32'(f_rd), 32'd1);
    chk("max bytes", 32'(n_v), 32'd752);
    chk("max span", 32'(l_eop - f_sop), 32'd751);
    chk("max pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Reset in the middle of a packet.
    @(negedge clk);
    rate_inc = 24'h800000; fifo_rd_count = 13'd200; enable = 1'b1;
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst ts_valid", 32'(ts_valid), 32'd0);
    chk("mid rst ts_data",  32'(ts_data),  32'd0);
    chk("mid rst ts_null",  32'(ts_null),  32'd0);
    chk("mid rst rd_en",    32'(fifo_rd_en), 32'd0);
    chk("mid rst pkt_cnt",  32'(pkt_cnt),  32'd0);
    chk("mid rst null_cnt", 32'(null_cnt), 32'd0);
    chk("mid rst acc",      32'(dut.acc),  32'd0);
    chk("mid rst idx",      32'(dut.idx),  32'd0);
    exp_pkt = 16'd0; exp_null = 16'd0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_phase("post rst", 24'h800000, 13'd200, 13'd200, 0, 2, n_rd, n_v, f_rd, f_sop, l_eop);
    chk("post rst sop latency", 32'(f_sop - f_rd), 32'd2);
    chk("post rst pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Counter wrap.
    @(negedge clk);
    force dut.pkt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_cnt;
    exp_pkt = 16'hFFFF;
    run_phase("wrap", 24'hC00000, 13'd300, 13'd300, 0, 2, n_rd, n_v, f_rd, f_sop, l_eop);
    chk("wrap pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Random rates, fill levels, count changes and enable drops.
    for (int r = 0; r < 6; r++) begin
      r_rate = 24'($urandom_range(24'hFFFFFF, 24'h200000));
      d = int'($urandom_range(600, 32'(tick_j(1, longint'(r_rate)))));
      run_phase("rand", r_rate, 13'($urandom_range(400, 0)), 13'($urandom_range(400, 0)),
                int'($urandom_range(800, 0)), d, n_rd, n_v, f_rd, f_sop, l_eop);
      chk("rand whole packets", 32'(n_v % 188), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
